// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: single-cycle-latency 32x32 multiply, 32-step restoring divide,
// MTHI/MTLO writes and combinational MFHI/MFLO reads, with cancel and synchronous reset.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_in0,
    input  logic [31:0] req_in1,
    output logic        req_ready,
    input  logic        rd_req,
    input  logic        rd_sel,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    input  logic        cancel,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    localparam int OP_MULT  = 0;
    localparam int OP_MULTU = 1;
    localparam int OP_DIV   = 2;
    localparam int OP_DIVU  = 3;
    localparam int OP_MTHI  = 4;

    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

    function automatic logic [63:0] ext64(input logic [31:0] v, input logic sgn);
        return {{32{sgn & v[31]}}, v};
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] op0_r;
    logic [31:0] op1_r;
    logic [31:0] raw0_r;
    logic [31:0] rem_r;
    logic [4:0]  cnt_r;
    logic        mul_signed_r;
    logic        neg_quo_r;
    logic        neg_rem_r;

    logic        accept_s;
    logic        is_mul_s;
    logic        is_div_s;
    logic        div_signed_s;
    logic [63:0] prod_s;
    logic [32:0] rem_shift_s;
    logic [32:0] diff_s;
    logic [31:0] rem_step_s;
    logic [31:0] quo_step_s;
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;
    logic        hi_we_s;
    logic        lo_we_s;
    logic [31:0] hi_nxt_s;
    logic [31:0] lo_nxt_s;

    assign req_ready    = (state_r == ST_IDLE);
    assign busy         = (state_r != ST_IDLE);
    assign rd_valid     = rd_req & req_ready;
    assign rd_data      = rd_sel ? hi_r : lo_r;

    assign accept_s     = req_valid & req_ready & ~cancel & is_onehot6(req_op);
    assign is_mul_s     = req_op[OP_MULT] | req_op[OP_MULTU];
    assign is_div_s     = req_op[OP_DIV] | req_op[OP_DIVU];
    assign div_signed_s = req_op[OP_DIV];
    // Low 64 bits of the product of sign- or zero-extended operands give the full product.
    assign prod_s       = ext64(op0_r, mul_signed_r) * ext64(op1_r, mul_signed_r);

    // One restoring shift-subtract step; op0_r doubles as the quotient shift register.
    always_comb begin
        rem_shift_s = {rem_r, op0_r[31]};
        diff_s      = rem_shift_s - {1'b0, op1_r};
        if (!diff_s[32]) begin
            rem_step_s = diff_s[31:0];
            quo_step_s = {op0_r[30:0], 1'b1};
        end else begin
            rem_step_s = rem_shift_s[31:0];
            quo_step_s = {op0_r[30:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero result applied in FIX.
    always_comb begin
        if (op1_r == 32'd0) begin
            fix_lo_s = 32'hFFFF_FFFF;
            fix_hi_s = raw0_r;
        end else begin
            fix_lo_s = neg_quo_r ? neg32(op0_r) : op0_r;
            fix_hi_s = neg_rem_r ? neg32(rem_r) : rem_r;
        end
    end

    // Next-state and HI/LO write selection.
    always_comb begin
        state_next_s = state_r;
        hi_we_s      = 1'b0;
        lo_we_s      = 1'b0;
        hi_nxt_s     = hi_r;
        lo_nxt_s     = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_mul_s) begin
                        state_next_s = ST_MUL;
                    end else if (is_div_s) begin
                        state_next_s = ST_DIV;
                    end else if (req_op[OP_MTHI]) begin
                        hi_we_s  = 1'b1;
                        hi_nxt_s = req_in0;
                    end else begin
                        lo_we_s  = 1'b1;
                        lo_nxt_s = req_in0;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                state_next_s = ST_IDLE;
                if (!cancel) begin
                    hi_we_s  = 1'b1;
                    lo_we_s  = 1'b1;
                    hi_nxt_s = prod_s[63:32];
                    lo_nxt_s = prod_s[31:0];
                end else begin
                    hi_we_s  = 1'b0;
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == 5'd31) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_DIV;
                end
            end
            ST_FIX: begin
                state_next_s = ST_IDLE;
                if (!cancel) begin
                    hi_we_s  = 1'b1;
                    lo_we_s  = 1'b1;
                    hi_nxt_s = fix_hi_s;
                    lo_nxt_s = fix_lo_s;
                end else begin
                    hi_we_s  = 1'b0;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // HI/LO architectural registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else begin
            if (hi_we_s) begin
                hi_r <= hi_nxt_s;
            end
            if (lo_we_s) begin
                lo_r <= lo_nxt_s;
            end
        end
    end

    // Operand capture and divide iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            op0_r        <= 32'd0;
            op1_r        <= 32'd0;
            raw0_r       <= 32'd0;
            rem_r        <= 32'd0;
            cnt_r        <= 5'd0;
            mul_signed_r <= 1'b0;
            neg_quo_r    <= 1'b0;
            neg_rem_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_mul_s) begin
                        op0_r        <= req_in0;
                        op1_r        <= req_in1;
                        mul_signed_r <= req_op[OP_MULT];
                    end else if (accept_s && is_div_s) begin
                        op0_r     <= div_signed_s ? abs32(req_in0) : req_in0;
                        op1_r     <= div_signed_s ? abs32(req_in1) : req_in1;
                        raw0_r    <= req_in0;
                        rem_r     <= 32'd0;
                        cnt_r     <= 5'd0;
                        neg_quo_r <= div_signed_s & (req_in0[31] ^ req_in1[31]);
                        neg_rem_r <= div_signed_s & req_in0[31];
                    end
                end
                ST_DIV: begin
                    if (!cancel) begin
                        op0_r <= quo_step_s;
                        rem_r <= rem_step_s;
                        cnt_r <= cnt_r + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
